matdet_scheduler: RTL and testbench

- Shares one matdetN determinant core among NUM_REQ requesters.
- Round-robin arbitration, one job in flight at a time.
- Latches the winning matrix and drives the core's rst/ready/complete start protocol.
- Returns the fixed-point determinant, tagged with the requester ID, via a valid/ready response port.
- Sits between the navigation pipeline stages and the single matdet instance.

---
 rtl/matdet_sched_pkg.sv | 23 ++
 rtl/matdet_scheduler_arbiter.sv | 35 +++
 rtl/matdet_scheduler.sv | 121 ++++++++++++
 tb/tb_matdet_scheduler.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matdet_sched_pkg.sv
// Shared FSM encodings and width helpers for the matdet scheduler.
// Everything here is elaboration-time only; no logic is generated.
package matdet_sched_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    function automatic int mat_w(input int matrix_size, input int data_width);
        return matrix_size * matrix_size * data_width;
    endfunction

    function automatic int id_w(input int num_req);
        return (num_req <= 2) ? 1 : $clog2(num_req);
    endfunction

    // Watchdog counter width; stays 1 bit when the watchdog is disabled.
    function automatic int wd_w(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/matdet_scheduler_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping.
// The pointer register lives in the scheduler so grants only advance on accept.
module rr_arbiter
    import matdet_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    int unsigned j;

    // NOTE: every output gets a default before the search loop; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = (int'(ptr) + i) % NUM_REQ;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/matdet_scheduler.sv
// Shares one matdet determinant core among NUM_REQ requesters, one job at a time,
// returning the determinant tagged with the owning requester's index.
module matdet_scheduler
    import matdet_sched_pkg::*;
#(
    parameter  int DATA_WIDTH  = 32,
    parameter  int BIN_POS     = 16,
    parameter  int MATRIX_SIZE = 3,
    parameter  int NUM_REQ     = 4,
    parameter  int TIMEOUT     = 0,
    localparam int MAT_W       = mat_w(MATRIX_SIZE, DATA_WIDTH),
    localparam int ID_W        = id_w(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*MAT_W-1:0]   req_matrix,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [ID_W-1:0]            resp_id,
    output logic [DATA_WIDTH-1:0]      resp_det,
    output logic                       resp_err,
    output logic                       core_rst,
    input  logic                       core_ready,
    input  logic                       core_complete,
    output logic [MAT_W-1:0]           core_matrix,
    input  logic [DATA_WIDTH-1:0]      core_det
);

    localparam int WD_W = wd_w(TIMEOUT);

    // BIN_POS only travels to the core; reject settings the core cannot honour.
    if (NUM_REQ < 2 || BIN_POS < 0 || BIN_POS >= DATA_WIDTH) begin : g_bad_params
        $error("matdet_scheduler: invalid parameter combination");
    end

    logic [1:0]         state;
    logic [ID_W-1:0]    ptr;
    logic [WD_W-1:0]    wd_cnt;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [ID_W-1:0]    arb_idx;
    logic               arb_any;
    logic [ID_W-1:0]    next_ptr;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req (req_valid),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    // Grants are offered only in IDLE, and never while reset is being applied.
    assign req_ready = (state == ST_IDLE && !rst) ? arb_gnt : '0;
    assign next_ptr  = (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + ID_W'(1);

    // NOTE: state registers use non-blocking assignment so every branch below
    // sees the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            wd_cnt      <= '0;
            core_rst    <= 1'b1;
            resp_valid  <= 1'b0;
            resp_id     <= '0;
            resp_det    <= '0;
            resp_err    <= 1'b0;
            // NOTE: the wide matrix latch is reset too, so the core never sees
            // stale data from a discarded job.
            core_matrix <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    core_rst <= 1'b1;
                    if (arb_any) begin
                        core_matrix <= req_matrix[arb_idx*MAT_W +: MAT_W];
                        resp_id     <= arb_idx;
                        ptr         <= next_ptr;
                        state       <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (core_ready) begin
                        core_rst <= 1'b0;
                        wd_cnt   <= '0;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    wd_cnt <= wd_cnt + WD_W'(1);
                    if (core_complete) begin
                        resp_det   <= core_det;
                        resp_err   <= 1'b0;
                        resp_valid <= 1'b1;
                        core_rst   <= 1'b1;
                        state      <= ST_RESP;
                    end else if (TIMEOUT != 0 && wd_cnt == WD_W'(TIMEOUT - 1)) begin
                        resp_det   <= '0;
                        resp_err   <= 1'b1;
                        resp_valid <= 1'b1;
                        core_rst   <= 1'b1;
                        state      <= ST_RESP;
                    end
                end
                default: begin
                    core_rst <= 1'b1;
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matdet_scheduler.sv
// Self-checking bench for matdet_scheduler with a behavioural 2x2 determinant core.
module tb_matdet_scheduler;

    localparam int DW  = 32;
    localparam int MW  = 128;
    localparam int NR  = 4;
    localparam int TO  = 50;
    localparam int LAT = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NR-1:0]   req_valid = '0;
    logic [NR-1:0]   req_ready;
    logic [NR*MW-1:0] req_matrix = '0;
    logic            resp_valid;
    logic            resp_ready = 1'b1;
    logic [1:0]      resp_id;
    logic [DW-1:0]   resp_det;
    logic            resp_err;
    logic            core_rst;
    logic            core_ready;
    logic            core_complete = 1'b0;
    logic [MW-1:0]   core_matrix;
    logic [DW-1:0]   core_det = '0;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0]  id;
        logic        err;
        logic [31:0] det;
    } resp_t;

    resp_t sb[$];
    logic  core_hang = 1'b0;
    int    core_cnt  = 0;

    always #5 clk = ~clk;

    matdet_scheduler #(
        .DATA_WIDTH  (DW),
        .BIN_POS     (16),
        .MATRIX_SIZE (2),
        .NUM_REQ     (NR),
        .TIMEOUT     (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_matrix    (req_matrix),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_id       (resp_id),
        .resp_det      (resp_det),
        .resp_err      (resp_err),
        .core_rst      (core_rst),
        .core_ready    (core_ready),
        .core_complete (core_complete),
        .core_matrix   (core_matrix),
        .core_det      (core_det)
    );

    function automatic logic [31:0] fx(input int v);
        return 32'(v <<< 16);
    endfunction

    function automatic logic [127:0] mk(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c, input logic [31:0] d);
        return {d, c, b, a};
    endfunction

    function automatic logic [31:0] ref_det(input logic [127:0] m);
        longint a, b, c, d, p;
        a = longint'($signed(m[31:0]));
        b = longint'($signed(m[63:32]));
        c = longint'($signed(m[95:64]));
        d = longint'($signed(m[127:96]));
        p = a * d - b * c;
        return 32'(p >>> 16);
    endfunction

    // Behavioural core: ready while held in reset, completes LAT cycles after release.
    assign core_ready = core_rst;
    always @(posedge clk) begin
        if (core_rst) begin
            core_cnt      <= 0;
            core_complete <= 1'b0;
        end else if (!core_hang) begin
            if (core_cnt == LAT - 1) begin
                core_complete <= 1'b1;
                core_det      <= ref_det(core_matrix);
            end else begin
                core_cnt <= core_cnt + 1;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: push on accept, pop and compare on response handshake.
    initial forever begin
        resp_t e;
        @(negedge clk);
        if (rst) begin
            sb.delete();
        end else begin
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    e.id  = 2'(i);
                    e.err = core_hang;
                    e.det = core_hang ? 32'd0 : ref_det(req_matrix[i*MW +: MW]);
                    sb.push_back(e);
                end
            end
            if (resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_resp", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("sb_resp", {resp_id, resp_err, resp_det}, {e.id, e.err, e.det});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=stalled expected=finish");
        $fatal(1, "bench stalled");
    end

    task automatic wait_grant(output logic ok);
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                ok = 1'b1;
                return;
            end
        end
        check("grant_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_resp(output logic ok);
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (resp_valid) begin
                ok = 1'b1;
                return;
            end
        end
        check("resp_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_core_run(output logic ok);
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (!core_rst) begin
                ok = 1'b1;
                return;
            end
        end
        check("run_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (sb.size() == 0 && !resp_valid) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        check("drain_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        req_valid = '0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_core_rst",    64'(core_rst),    64'd1);
        check("rst_req_ready",   64'(req_ready),   64'd0);
        check("rst_resp_valid",  64'(resp_valid),  64'd0);
        check("rst_resp_id",     64'(resp_id),     64'd0);
        check("rst_resp_det",    64'(resp_det),    64'd0);
        check("rst_resp_err",    64'(resp_err),    64'd0);
        check("rst_core_matrix", 64'(|core_matrix), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Serve n grants; order packs the expected winner of grant k at [2k +: 2].
    task automatic run_jobs(input logic [7:0] order, input int n);
        logic ok;
        int   g;
        for (int k = 0; k < n; k++) begin
            wait_grant(ok);
            if (!ok) return;
            check("rr_order", 64'(req_ready), 64'(4'b0001 << order[2*k +: 2]));
            g = 0;
            for (int i = 0; i < NR; i++) if (req_ready[i]) g = i;
            @(posedge clk);
            #1 req_valid[g] = 1'b0;
        end
        wait_drain();
    endtask

    typedef struct {
        int           id;
        logic [127:0] m;
        logic [31:0]  exp_det;
    } vec_t;

    vec_t tbl[5];

    initial begin
        logic ok;
        int   n;

        tbl[0] = '{2, mk(fx(3), fx(1), fx(2), fx(4)),       32'h000A0000};
        tbl[1] = '{0, mk(fx(1), fx(2), fx(3), fx(4)),       32'hFFFE0000};
        tbl[2] = '{1, mk(fx(1), 32'd0, 32'd0, fx(1)),       32'h00010000};
        tbl[3] = '{3, mk(fx(2), 32'd0, 32'd0, fx(-3)),      32'hFFFA0000};
        tbl[4] = '{0, mk(32'h8000, 32'd0, 32'd0, 32'h8000), 32'h00004000};

        do_reset();

        // Single-requester jobs from the vector table.
        for (int v = 0; v < 5; v++) begin
            req_matrix[tbl[v].id*MW +: MW] = tbl[v].m;
            req_valid[tbl[v].id] = 1'b1;
            wait_grant(ok);
            if (ok) begin
                check("tbl_grant", 64'(req_ready), 64'(4'b0001 << tbl[v].id));
                @(posedge clk);
                #1 req_valid[tbl[v].id] = 1'b0;
                @(negedge clk);
                check("tbl_grant_one_cycle", 64'(req_ready), 64'd0);
                check("tbl_load_core_rst",   64'(core_rst),  64'd1);
                wait_resp(ok);
                if (ok) begin
                    check("tbl_resp_id",  64'(resp_id),  64'(tbl[v].id));
                    check("tbl_resp_det", 64'(resp_det), 64'(tbl[v].exp_det));
                    check("tbl_resp_err", 64'(resp_err), 64'd0);
                end
                @(posedge clk);
                #1;
            end
        end
        wait_drain();

        // Round-robin fairness from a freshly reset pointer.
        do_reset();
        for (int i = 0; i < NR; i++) req_matrix[i*MW +: MW] = mk(fx(i + 1), 32'd0, 32'd0, fx(2));
        req_valid = 4'b1111;
        run_jobs({2'd3, 2'd2, 2'd1, 2'd0}, 4);
        req_valid = 4'b1001;
        run_jobs({2'd0, 2'd0, 2'd3, 2'd0}, 2);

        // Response backpressure while other requesters wait.
        resp_ready = 1'b0;
        req_matrix[0 +: MW] = mk(fx(5), 32'd0, 32'd0, fx(1));
        req_valid[0] = 1'b1;
        wait_grant(ok);
        if (ok) check("bp_grant", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        req_valid[3:1] = 3'b111;
        wait_resp(ok);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("bp_hold", {resp_valid, req_ready, core_rst, resp_id, resp_det},
                  {1'b1, 4'b0000, 1'b1, 2'd0, 32'h00050000});
        end
        @(posedge clk);
        #1 resp_ready = 1'b1;
        run_jobs({2'd0, 2'd3, 2'd2, 2'd1}, 3);

        // Reset while a job is running; the requester keeps asking and is re-served.
        req_matrix[1*MW +: MW] = mk(fx(2), fx(1), fx(1), fx(3));
        req_valid[1] = 1'b1;
        wait_core_run(ok);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_core_rst",   64'(core_rst),   64'd1);
        check("midrst_resp_valid", 64'(resp_valid), 64'd0);
        check("midrst_regrant",    64'(req_ready),  64'b0010);
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        wait_resp(ok);
        if (ok) check("midrst_resp", {resp_id, resp_err, resp_det}, {2'd1, 1'b0, 32'h00050000});
        wait_drain();

        // Watchdog: a core that never completes is aborted after TO run cycles.
        core_hang = 1'b1;
        req_matrix[3*MW +: MW] = mk(fx(1), 32'd0, 32'd0, fx(1));
        req_valid[3] = 1'b1;
        wait_grant(ok);
        if (ok) check("wd_grant", 64'(req_ready), 64'b1000);
        @(posedge clk);
        #1 req_valid[3] = 1'b0;
        wait_core_run(ok);
        n = 0;
        while (!core_rst && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("wd_run_cycles", 64'(n), 64'(TO));
        check("wd_resp", {resp_valid, resp_err, resp_det}, {1'b1, 1'b1, 32'd0});
        wait_drain();
        core_hang = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
